// File: rtl/pedal_audio_pkg.sv
// Shared definitions for the pedal audio path.
//   SAMPLE_W        : default bits per channel word
//   stereo_sample_t : {left, right} sample pair, left in the upper half
//   i2s_state_e     : transmitter state (IDLE / RUN)
//   lr_for_slot     : word-select level for a given BCLK slot of a frame
package pedal_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    I2S_IDLE = 1'b0,
    I2S_RUN  = 1'b1
  } i2s_state_e;

  // LRCLK leads the word MSB by one slot, so the right-channel select spans
  // slots DATA_W-1 .. 2*DATA_W-2 of the frame.
  function automatic logic lr_for_slot(input int slot, input int data_w);
    return (slot >= data_w - 1) && (slot <= 2 * data_w - 2);
  endfunction

endpackage

// File: rtl/pedal_sample_fifo.sv
// Synchronous FIFO holding stereo sample pairs between the DSP core and the
// I2S serialiser. Read data is the current head (show-ahead); a read only
// advances the head. Writes when full and reads when empty are ignored.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties FIFO)
//   wr_en, wr_data  : write strobe and data
//   rd_en, rd_data  : pop strobe and head data
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module pedal_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pedal_i2s_tx.sv
// I2S master transmitter for the pedal output path. Stereo samples arrive on
// a valid/ready stream, are buffered in pedal_sample_fifo and serialised MSB
// first as {left, right} frames of 2*DATA_W BCLK slots.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   ena               : transmitter enable (0 = IDLE, outputs held low)
//   s_valid, s_ready  : sample stream handshake
//   s_left, s_right   : two's complement channel samples
//   bclk, lrclk, sdata: I2S bit clock, word select (0 = left), serial data
//   underflow         : sticky, a frame started with the FIFO empty
//   clr_uf            : single-cycle clear of underflow
//   dbg_state         : current transmitter state
module pedal_i2s_tx
  import pedal_audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underflow,
  input  logic              clr_uf,
  output i2s_state_e        dbg_state
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W  = $clog2(FRAME_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);

  i2s_state_e         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;     // slot started by the next falling BCLK
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               uf_q, uf_d;

  logic               push;
  logic               pop;
  logic [FRAME_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Stream handshake: a pair transfers on a clk edge where s_valid and
  // s_ready are both 1. s_ready reflects the FIFO occupancy before that
  // edge's pop, so a slot popped this cycle is only reusable next cycle.
  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;

  pedal_sample_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({s_left, s_right}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    uf_d    = uf_q;
    pop     = 1'b0;

    // A same-cycle underflow set below overrides this clear.
    if (clr_uf) uf_d = 1'b0;

    case (state_q)
      I2S_IDLE: begin
        div_d   = '0;
        slot_d  = '0;
        shreg_d = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        if (ena) state_d = I2S_RUN;
      end
      I2S_RUN: begin
        if (!ena) begin
          // Abort: any frame in flight is dropped, FIFO contents kept.
          state_d = I2S_IDLE;
          div_d   = '0;
          slot_d  = '0;
          shreg_d = '0;
          bclk_d  = 1'b0;
          lrclk_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = !bclk_q;
          if (bclk_q) begin
            // BCLK falling: data and word select change here so the DAC
            // sees them stable on the following rising edge.
            lrclk_d = lr_for_slot(32'(slot_q), DATA_W);
            if (slot_q == '0) begin
              if (fifo_empty) begin
                shreg_d = '0;
                uf_d    = 1'b1;
              end else begin
                shreg_d = fifo_head;
                pop     = 1'b1;
              end
            end else begin
              shreg_d = shreg_q << 1;
            end
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = I2S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= I2S_IDLE;
      div_q   <= '0;
      slot_q  <= '0;
      shreg_q <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      shreg_q <= shreg_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      uf_q    <= uf_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = shreg_q[FRAME_W-1];
  assign underflow = uf_q;
  assign dbg_state = state_q;

  // The full flag and the occupancy count describe the same FIFO state.
  a_full_matches_count: assert property (
    @(posedge clk) disable iff (rst)
      fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_pedal_i2s_tx.sv
module tb_pedal_i2s_tx;
  import pedal_audio_pkg::*;

  localparam int DATA_W     = 16;
  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FW         = 2 * DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              underflow;
  logic              clr_uf;
  i2s_state_e        dbg_state;

  always #5 clk = ~clk;

  pedal_i2s_tx #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_left    (s_left),
    .s_right   (s_right),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .underflow (underflow),
    .clr_uf    (clr_uf),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [FW-1:0] exp_q[$];      // accepted pairs not yet played
  int            exp_cyc_q[$];  // clk edge number on which each was accepted

  int            cyc = 0;
  bit            m_run = 0;
  int            m_div = 0;
  bit            m_bclk = 0;
  bit            m_fall = 0;
  bit            m_uf = 0;
  int            m_slot = 0;
  int            frames = 0;
  int            last_pop_cyc = -1;
  logic [FW-1:0] cur_exp = '0;
  logic [FW-1:0] got_word = '0;
  logic [FW-1:0] got_lr = '0;
  logic [FW-1:0] last_word = '0;
  logic [FW-1:0] lr_pat;

  // Timing model: divider, BCLK level and falling-edge events per clk edge.
  always @(posedge clk) begin
    cyc++;
    m_fall = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_div  = 0;
      m_bclk = 1'b0;
      m_uf   = 1'b0;
    end else begin
      if (clr_uf) m_uf = 1'b0;
      if (!m_run) begin
        if (ena) m_run = 1'b1;
      end else if (!ena) begin
        m_run  = 1'b0;
        m_div  = 0;
        m_bclk = 1'b0;
      end else if (m_div == CLK_DIV - 1) begin
        m_div  = 0;
        m_fall = m_bclk;
        m_bclk = !m_bclk;
      end else begin
        m_div++;
      end
    end
  end

  // Monitor: sample the DUT mid-cycle, collect frames and compare.
  always @(negedge clk) begin
    if (rst || !m_run) m_slot = 0;
    if (!rst) begin
      if (m_fall) begin
        if (m_slot == 0) begin
          if (exp_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            cur_exp = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            last_pop_cyc = cyc;
          end else begin
            cur_exp = '0;
            m_uf    = 1'b1;
          end
          got_word = '0;
          got_lr   = '0;
        end
        got_word = {got_word[FW-2:0], sdata};
        got_lr   = {got_lr[FW-2:0], lrclk};
        if (m_slot == FW - 1) begin
          check("frame_data", got_word, cur_exp);
          check("frame_lrclk", got_lr, lr_pat);
          last_word = got_word;
          frames++;
        end
        m_slot = (m_slot == FW - 1) ? 0 : m_slot + 1;
      end
      check("bclk", 32'(bclk), 32'(m_bclk));
      check("underflow", 32'(underflow), 32'(m_uf));
      if (!m_run) begin
        check("idle_sdata", 32'(sdata), 32'd0);
        check("idle_lrclk", 32'(lrclk), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                           output bit acc);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    acc     = s_ready;
    if (acc) begin
      exp_q.push_back({l, r});
      exp_cyc_q.push_back(cyc + 1);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic push_hold(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                           output int acc_cyc);
    int budget = 2000;
    acc_cyc = -1;
    s_left  = l;
    s_right = r;
    while (acc_cyc < 0 && budget > 0) begin
      s_valid = 1'b1;
      if (s_ready) begin
        exp_q.push_back({l, r});
        exp_cyc_q.push_back(cyc + 1);
        acc_cyc = cyc + 1;
      end
      step();
      budget--;
    end
    s_valid = 1'b0;
    if (acc_cyc < 0) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int n);
    int target = frames + n;
    int budget = n * 200 + 200;
    while (frames < target && budget > 0) begin
      step();
      budget--;
    end
    if (frames < target) check("frame_timeout", 32'(frames), 32'(target));
  endtask

  task automatic wait_slot(input int s);
    int budget = 400;
    while (m_slot != s && budget > 0) begin
      step();
      budget--;
    end
    if (m_slot != s) check("slot_timeout", 32'(m_slot), 32'(s));
  endtask

  task automatic pulse_clr();
    clr_uf = 1'b1;
    step();
    clr_uf = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit            acc;
  int            acc_cyc;
  logic [FW-1:0] w1, w2;
  logic [FW-1:0] d [5];

  initial begin
    for (int s = 0; s < FW; s++)
      lr_pat[FW-1-s] = (s >= DATA_W - 1) && (s <= 2 * DATA_W - 2);

    rst = 1'b1; ena = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0; clr_uf = 1'b0;
    repeat (3) step();
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrclk", 32'(lrclk), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(I2S_IDLE));
    rst = 1'b0;
    step();

    // Known pattern into an empty FIFO, played in the first frame.
    push_pair(16'hA5A5, 16'h0F0F, acc);
    check("t1_acc", 32'(acc), 32'd1);
    ena = 1'b1;
    wait_frames(1);
    check("t1_word", last_word, 32'hA5A50F0F);
    check("t1_uf", 32'(underflow), 32'd0);
    ena = 1'b0;
    step();

    // Empty FIFO: silent frame and underflow, then clear and play a sample.
    ena = 1'b1;
    wait_frames(1);
    check("t2_word", last_word, 32'd0);
    check("t2_uf_set", 32'(underflow), 32'd1);
    wait_slot(5);
    pulse_clr();
    step();
    check("t2_uf_clr", 32'(underflow), 32'd0);
    w1 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    push_pair(w1[31:16], w1[15:0], acc);
    check("t2_acc", 32'(acc), 32'd1);
    wait_frames(2);
    check("t2_word_play", last_word, w1);
    ena = 1'b0;
    repeat (2) step();
    pulse_clr();

    // Back-to-back pushes while idle: fifth refused, then held until a
    // pop frees space. It must land the cycle after the pop, not with it.
    for (int i = 0; i < 5; i++) begin
      d[i] = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      if (i < 4) begin
        push_pair(d[i][31:16], d[i][15:0], acc);
        check("t3_acc", 32'(acc), 32'd1);
      end else begin
        push_pair(d[i][31:16], d[i][15:0], acc);
        check("t3_acc_full", 32'(acc), 32'd0);
      end
      if (i == 3) check("t3_ready_full", 32'(s_ready), 32'd0);
    end
    ena = 1'b1;
    push_hold(d[4][31:16], d[4][15:0], acc_cyc);
    check("t4_accept_after_pop", 32'(acc_cyc), 32'(last_pop_cyc + 1));
    wait_frames(5);
    check("t3_played_all", 32'(exp_q.size()), 32'd0);
    check("t3_last_word", last_word, d[4]);
    ena = 1'b0;
    repeat (2) step();

    // Reset in the middle of slot 10 while underflow is set and FIFO holds data.
    ena = 1'b1;
    wait_frames(1);
    check("t5_uf_pre", 32'(underflow), 32'd1);
    push_pair(16'h1234, 16'h5678, acc);
    push_pair(16'h9ABC, 16'hDEF0, acc);
    wait_slot(11);
    step();
    #1 rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("t5_bclk", 32'(bclk), 32'd0);
    check("t5_lrclk", 32'(lrclk), 32'd0);
    check("t5_sdata", 32'(sdata), 32'd0);
    check("t5_underflow", 32'(underflow), 32'd0);
    check("t5_s_ready", 32'(s_ready), 32'd1);
    check("t5_state", 32'(dbg_state), 32'(I2S_IDLE));
    repeat (2) step();
    rst = 1'b0;
    wait_frames(1);
    check("t5_fifo_emptied", last_word, 32'd0);
    check("t5_uf_after", 32'(underflow), 32'd1);
    ena = 1'b0;
    step();
    pulse_clr();

    // Abort mid-frame: first sample lost, second starts cleanly at slot 0.
    w1 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    w2 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    push_pair(w1[31:16], w1[15:0], acc);
    push_pair(w2[31:16], w2[15:0], acc);
    ena = 1'b1;
    wait_slot(21);
    ena = 1'b0;
    step();
    check("t6_bclk", 32'(bclk), 32'd0);
    check("t6_lrclk", 32'(lrclk), 32'd0);
    check("t6_sdata", 32'(sdata), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(I2S_IDLE));
    ena = 1'b1;
    wait_frames(1);
    check("t6_word", last_word, w2);
    check("t6_uf", 32'(underflow), 32'd0);
    ena = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
